// File: rtl/dcol_hit_encoder.sv
// Pixel-side end of the double-column readout.
//
// Holds the latched hit map of one double column and hands pending hits to
// the reader one at a time, lowest pixel index first. Each hit is presented
// as a 15-bit address {dcol_id, pixel index}.
//
// Parameters
//   NPIX         pixels per double column (power of two, at most 256)
//   PW           pixel-index width, log2(NPIX)
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       asynchronous active-low reset
//   sel_i        column enable; 0 freezes the block (resetpe_i still acts)
//   dcol_id_i    double-column number, passed straight to addrin_o[14:8]
//   hit_in_i     raw pixel hit flags
//   strobe_i     capture pulse, ORs hit_in_i into the hit map
//   readin_i     consume pulse from the reader
//   resetpe_i    clear of all pending hits
//   addrin_o     {dcol_id, pixel index} of the presented hit
//   full_o       addrin_o holds a valid, unconsumed address
//   empty_o      nothing pending (hit map zero and full_o low)
module dcol_hit_encoder #(
  parameter int unsigned NPIX = 256,
  parameter int unsigned PW   = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            sel_i,
  input  logic [6:0]      dcol_id_i,
  input  logic [NPIX-1:0] hit_in_i,
  input  logic            strobe_i,
  input  logic            readin_i,
  input  logic            resetpe_i,
  output logic [14:0]     addrin_o,
  output logic            full_o,
  output logic            empty_o
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPresent
  } state_e;

  state_e          state_q;
  logic [NPIX-1:0] hitmap_q;
  logic [NPIX-1:0] hitmap_d;
  logic [NPIX-1:0] consume_mask;
  logic [NPIX-1:0] set_mask;
  logic [PW-1:0]   idx_q;
  logic [PW-1:0]   low_idx;
  logic            full_q;
  logic            consume;
  logic [7:0]      pix_addr;

  // Lowest set index of the hit map. Scanning downwards lets the last
  // (lowest) match win.
  always_comb begin
    low_idx = '0;
    for (int i = NPIX - 1; i >= 0; i--) begin
      if (hitmap_q[i]) begin
        low_idx = PW'(i);
      end
    end
  end

  // A consume only counts while an address is actually presented, so a held
  // readin cannot eat the address being loaded.
  assign consume = sel_i & readin_i & (state_q == StPresent);

  always_comb begin
    consume_mask         = '0;
    consume_mask[idx_q]  = consume;
    set_mask             = (sel_i & strobe_i) ? hit_in_i : '0;
    // Clear before OR so a same-cycle re-hit on the consumed pixel survives.
    hitmap_d             = (hitmap_q & ~consume_mask) | set_mask;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      hitmap_q <= '0;
      idx_q    <= '0;
      full_q   <= 1'b0;
    end else if (resetpe_i) begin
      // Overrides strobe/readin and aborts any address in flight.
      state_q  <= StIdle;
      hitmap_q <= '0;
      idx_q    <= '0;
      full_q   <= 1'b0;
    end else if (sel_i) begin
      hitmap_q <= hitmap_d;
      unique case (state_q)
        StIdle: begin
          if (hitmap_q != '0) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          idx_q   <= low_idx;
          full_q  <= 1'b1;
          state_q <= StPresent;
        end
        StPresent: begin
          if (consume) begin
            full_q  <= 1'b0;
            state_q <= (hitmap_d != '0) ? StLoad : StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel index always occupies addrin[7:0]; unused upper bits stay zero.
  always_comb begin
    pix_addr         = '0;
    pix_addr[PW-1:0] = idx_q;
  end

  assign addrin_o = {dcol_id_i, pix_addr};
  assign full_o   = full_q;
  assign empty_o  = (hitmap_q == '0) & ~full_q;

endmodule

// File: tb/tb_dcol_hit_encoder.sv
// Bench for dcol_hit_encoder: directed scenarios plus randomized bursts.
// The driver pushes every address it expects into exp_q (sorted ascending per
// burst); the monitor pops one entry each time full rises and compares.
module tb_dcol_hit_encoder;

  localparam int NPIX = 256;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            sel     = 1'b1;
  logic [6:0]      dcol_id = '0;
  logic [NPIX-1:0] hit_in  = '0;
  logic            strobe  = 1'b0;
  logic            readin  = 1'b0;
  logic            resetpe = 1'b0;
  logic [14:0]     addrin;
  logic            full;
  logic            empty;

  dcol_hit_encoder #(
    .NPIX(256),
    .PW  (8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sel_i    (sel),
    .dcol_id_i(dcol_id),
    .hit_in_i (hit_in),
    .strobe_i (strobe),
    .readin_i (readin),
    .resetpe_i(resetpe),
    .addrin_o (addrin),
    .full_o   (full),
    .empty_o  (empty)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [14:0] exp_q[$];
  int          cyc_cnt   = 0;
  int          last_rise = 0;
  int          last_gap  = 0;
  logic        prev_full = 1'b0;
  logic [14:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every new presentation must match the head of the scoreboard.
  always @(negedge clk) begin
    cyc_cnt++;
    if (rst_n && full && !prev_full) begin
      last_gap  = cyc_cnt - last_rise;
      last_rise = cyc_cnt;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_present: got %0h, expected none", addrin);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("present_addr", {17'd0, addrin}, {17'd0, mon_exp});
      end
    end
    prev_full = full;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the falling edge, well away from posedge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_full();
    int k = 0;
    while (!full && k < 60) begin
      cyc();
      k++;
    end
    if (!full) begin
      total++;
      bad++;
      $display("FAIL wait_full: got full=0, expected 1 within 60 cycles");
    end
  endtask

  task automatic consume(input int hold);
    readin = 1'b1;
    cycles(hold);
    readin = 1'b0;
  endtask

  // Strobe a hit mask; optionally queue its addresses in ascending order.
  task automatic strobe_bits(input logic [NPIX-1:0] m, input bit push);
    hit_in = m;
    strobe = 1'b1;
    cyc();
    strobe = 1'b0;
    hit_in = '0;
    if (push) begin
      for (int i = 0; i < NPIX; i++) begin
        if (m[i]) exp_q.push_back({dcol_id, 8'(i)});
      end
    end
  endtask

  logic [NPIX-1:0] m;
  int              n;

  initial begin
    // Reset state
    cycles(2);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_addr", {17'd0, addrin}, 32'd0);
    rst_n = 1'b1;
    cycles(3);
    chk("idle_empty", {31'd0, empty}, 32'd1);

    // Single hit, latency N / N+1 / N+2
    m = '0;
    m[8'hA1] = 1'b1;
    strobe_bits(m, 1'b1);
    chk("lat_n_full", {31'd0, full}, 32'd0);
    chk("lat_n_empty", {31'd0, empty}, 32'd0);
    cyc();
    chk("lat_n1_full", {31'd0, full}, 32'd0);
    cyc();
    chk("lat_n2_full", {31'd0, full}, 32'd1);
    chk("lat_n2_addr", {17'd0, addrin}, 32'h00A1);
    consume(1);
    chk("single_full", {31'd0, full}, 32'd0);
    chk("single_empty", {31'd0, empty}, 32'd1);

    // Ordering of eight hits, minimum spacing two cycles
    m = '0;
    for (int a = 8'hA1; a <= 8'hAF; a += 2) m[a] = 1'b1;
    strobe_bits(m, 1'b1);
    for (int j = 0; j < 8; j++) begin
      wait_full();
      if (j > 0) chk("spacing", last_gap, 32'd2);
      consume(1);
      chk("order_full_drop", {31'd0, full}, 32'd0);
    end
    chk("order_empty", {31'd0, empty}, 32'd1);

    // Strobe colliding with readin on the same pixel
    m = '0;
    m[8'hA1] = 1'b1;
    m[8'hA5] = 1'b1;
    strobe_bits(m, 1'b1);
    wait_full();
    m = '0;
    m[8'hA1] = 1'b1;
    hit_in = m;
    strobe = 1'b1;
    readin = 1'b1;
    exp_q.push_front({dcol_id, 8'hA1});
    cyc();
    strobe = 1'b0;
    readin = 1'b0;
    hit_in = '0;
    for (int j = 0; j < 2; j++) begin
      wait_full();
      consume(1);
    end
    chk("coll_empty", {31'd0, empty}, 32'd1);

    // resetpe together with strobe: nothing may be presented
    m = '0;
    m[8'hA1] = 1'b1;
    hit_in = m;
    strobe = 1'b1;
    resetpe = 1'b1;
    cyc();
    strobe = 1'b0;
    resetpe = 1'b0;
    hit_in = '0;
    chk("rpe_strobe_empty", {31'd0, empty}, 32'd1);
    cycles(6);
    chk("rpe_strobe_empty2", {31'd0, empty}, 32'd1);

    // resetpe while presenting aborts the rest
    m = '0;
    m[8'hA1] = 1'b1;
    m[8'hA3] = 1'b1;
    strobe_bits(m, 1'b1);
    wait_full();
    resetpe = 1'b1;
    readin = 1'b1;
    exp_q.delete();
    cyc();
    resetpe = 1'b0;
    readin = 1'b0;
    chk("rpe_full", {31'd0, full}, 32'd0);
    chk("rpe_empty", {31'd0, empty}, 32'd1);
    cycles(5);
    chk("rpe_empty2", {31'd0, empty}, 32'd1);

    // Freeze with sel=0: readin and strobe ignored
    dcol_id = 7'h15;
    m = '0;
    m[8'hA1] = 1'b1;
    m[8'hA3] = 1'b1;
    m[8'hA5] = 1'b1;
    strobe_bits(m, 1'b1);
    wait_full();
    consume(1);
    wait_full();
    sel = 1'b0;
    readin = 1'b1;
    m = '0;
    m[8'h10] = 1'b1;
    hit_in = m;
    strobe = 1'b1;
    cyc();
    strobe = 1'b0;
    readin = 1'b0;
    hit_in = '0;
    cycles(2);
    chk("freeze_full", {31'd0, full}, 32'd1);
    chk("freeze_addr", {17'd0, addrin}, {17'd0, 7'h15, 8'hA3});
    sel = 1'b1;
    cyc();
    consume(1);
    wait_full();
    consume(1);
    chk("freeze_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset mid-presentation
    dcol_id = 7'h00;
    m = '0;
    m[8'hA1] = 1'b1;
    m[8'hA3] = 1'b1;
    strobe_bits(m, 1'b1);
    wait_full();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_full", {31'd0, full}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_addr", {24'd0, addrin[7:0]}, 32'd0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    cycles(5);
    chk("arst_empty2", {31'd0, empty}, 32'd1);
    chk("arst_full2", {31'd0, full}, 32'd0);

    // Randomized bursts with random consume timing and freezes
    for (int it = 0; it < 25; it++) begin
      dcol_id = 7'($urandom);
      m = '0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) m[$urandom_range(0, NPIX - 1)] = 1'b1;
      strobe_bits(m, 1'b1);
      n = $countones(m);
      for (int j = 0; j < n; j++) begin
        wait_full();
        cycles($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          sel = 1'b0;
          readin = 1'b1;
          cyc();
          chk("rand_freeze_full", {31'd0, full}, 32'd1);
          sel = 1'b1;
          readin = 1'b0;
        end
        consume($urandom_range(1, 2));
      end
      cyc();
      chk("rand_empty", {31'd0, empty}, 32'd1);
    end

    cycles(3);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
